// File: rtl/sram_delay_line.sv
// Programmable sample delay line built on an external single-port SRAM ring.
// Each sample reads the oldest ring entry, then overwrites it with itself.
module sram_delay_line #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 20,
  parameter int unsigned MAX_DELAY = 8044,
  parameter int unsigned WAIT_CYC  = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_bypass,
  input  logic [ADDR_W-1:0] i_delay,
  input  logic              i_delay_load,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_primed,
  output logic [ADDR_W-1:0] o_s_addr,
  output logic [DATA_W-1:0] o_s_data,
  output logic              o_s_wen,
  input  logic [DATA_W-1:0] i_s_data
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic [2:0] {IDLE, READ, RWAIT, WRITE, WWAIT} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic [ADDR_W-1:0] dly, dly_nxt;
  logic              ready_nxt;
  logic              valid_nxt;
  logic              primed_nxt;
  logic              wen_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic [DATA_W-1:0] s_data_nxt;
  logic [ADDR_W-1:0] s_addr_nxt;

  // A zero delay is meaningless for a ring, so it becomes one sample.
  function automatic logic [ADDR_W-1:0] clamp(input logic [ADDR_W-1:0] d);
    if (d == '0) return ADDR_W'(1);
    if (d > ADDR_W'(MAX_DELAY)) return ADDR_W'(MAX_DELAY);
    return d;
  endfunction

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= IDLE;
      cnt      <= '0;
      ptr      <= '0;
      dly      <= ADDR_W'(MAX_DELAY);
      o_ready  <= 1'b1;
      o_valid  <= 1'b0;
      o_primed <= 1'b0;
      o_data   <= '0;
      o_s_addr <= '0;
      o_s_data <= '0;
      o_s_wen  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      ptr      <= ptr_nxt;
      dly      <= dly_nxt;
      o_ready  <= ready_nxt;
      o_valid  <= valid_nxt;
      o_primed <= primed_nxt;
      o_data   <= data_nxt;
      o_s_addr <= s_addr_nxt;
      o_s_data <= s_data_nxt;
      o_s_wen  <= wen_nxt;
    end
  end

  // Next-state and registered-output values.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    ptr_nxt    = ptr;
    dly_nxt    = dly;
    primed_nxt = o_primed;
    valid_nxt  = 1'b0;
    wen_nxt    = 1'b0;
    data_nxt   = o_data;
    s_addr_nxt = o_s_addr;
    s_data_nxt = o_s_data;

    unique case (state)
      IDLE: begin
        if (i_delay_load) begin
          dly_nxt    = clamp(i_delay);
          ptr_nxt    = '0;
          primed_nxt = 1'b0;
        end else if (i_valid) begin
          if (i_bypass) begin
            data_nxt  = i_data;
            valid_nxt = 1'b1;
          end else begin
            s_data_nxt = i_data;
            s_addr_nxt = ptr;
            state_nxt  = READ;
          end
        end
      end
      READ: begin
        cnt_nxt   = CNT_W'(WAIT_CYC - 1);
        state_nxt = RWAIT;
      end
      RWAIT: begin
        if (cnt == '0) begin
          // Until the ring has wrapped once the SRAM holds stale data.
          data_nxt  = o_primed ? i_s_data : '0;
          valid_nxt = 1'b1;
          wen_nxt   = 1'b1;
          state_nxt = WRITE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      WRITE: begin
        cnt_nxt   = CNT_W'(WAIT_CYC - 1);
        state_nxt = WWAIT;
      end
      WWAIT: begin
        if (cnt == '0) begin
          if (ptr == dly - ADDR_W'(1)) begin
            ptr_nxt    = '0;
            primed_nxt = 1'b1;
          end else begin
            ptr_nxt = ptr + ADDR_W'(1);
          end
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    ready_nxt = (state_nxt == IDLE);
  end

endmodule

// File: tb/tb_sram_delay_line.sv
// Randomised scoreboard bench for sram_delay_line with a behavioural SRAM.
module tb_sram_delay_line;

  localparam int unsigned DW   = 16;
  localparam int unsigned AW   = 20;
  localparam int unsigned MAXD = 8044;
  localparam int unsigned W    = 1;

  logic          i_clk, i_rst;
  logic          i_valid, o_ready, i_bypass, i_delay_load;
  logic [DW-1:0] i_data, o_data, o_s_data, i_s_data;
  logic [AW-1:0] i_delay, o_s_addr;
  logic          o_valid, o_primed, o_s_wen;

  sram_delay_line #(.DATA_W(DW), .ADDR_W(AW), .MAX_DELAY(MAXD), .WAIT_CYC(W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .i_bypass(i_bypass), .i_delay(i_delay),
    .i_delay_load(i_delay_load), .o_valid(o_valid), .o_data(o_data),
    .o_primed(o_primed), .o_s_addr(o_s_addr), .o_s_data(o_s_data),
    .o_s_wen(o_s_wen), .i_s_data(i_s_data)
  );

  typedef struct {logic [DW-1:0] data; logic primed; int cyc;} exp_t;
  typedef struct {logic [AW-1:0] addr; logic [DW-1:0] data; int cyc;} wr_t;

  exp_t          exp_q[$];
  wr_t           wr_q[$];
  logic [DW-1:0] hist[$];
  logic [DW-1:0] mem [0:8191];
  int            n_vec = 0, n_err = 0, cyc = 0;
  int            dly_m = MAXD, k_m = 0, busy_lo = 0, busy_hi = -1;
  logic          in_rst = 1'b1;
  logic          ev, ew;

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  always @(posedge i_clk) cyc <= cyc + 1;

  // SRAM: asynchronous read; junk preload makes unprimed reads visible.
  assign i_s_data = mem[o_s_addr[12:0]];
  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 16'hDEAD ^ 16'(i);
    forever begin
      @(negedge i_clk);
      if (o_s_wen) mem[o_s_addr[12:0]] = o_s_data;
    end
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endfunction

  function automatic int clamp_m(input int v);
    if (v == 0) return 1;
    if (v > int'(MAXD)) return MAXD;
    return v;
  endfunction

  // One input cycle; the reference model acts only when the DUT is ready.
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic byp,
                       input logic ld, input logic [AW-1:0] dl, output logic acc);
    exp_t e;
    wr_t  w;
    @(posedge i_clk);
    #1;
    i_valid = v; i_data = d; i_bypass = byp; i_delay_load = ld; i_delay = dl;
    acc = 1'b0;
    if (o_ready) begin
      if (ld) begin
        dly_m = clamp_m(int'(dl)); k_m = 0; hist.delete(); acc = 1'b1;
      end else if (v && byp) begin
        e.data = d; e.primed = (k_m >= dly_m); e.cyc = cyc + 1;
        exp_q.push_back(e); acc = 1'b1;
      end else if (v) begin
        e.primed = (k_m >= dly_m);
        e.data   = e.primed ? hist[k_m - dly_m] : '0;
        e.cyc    = cyc + 2 + W;
        exp_q.push_back(e);
        w.addr = AW'(k_m % dly_m); w.data = d; w.cyc = cyc + 2 + W;
        wr_q.push_back(w);
        hist.push_back(d);
        k_m++;
        busy_lo = cyc + 1; busy_hi = cyc + 2 + 2 * W;
        acc = 1'b1;
      end
    end
  endtask

  task automatic feed(input logic [DW-1:0] d, input logic byp);
    logic acc;
    int   n;
    acc = 1'b0; n = 0;
    while (!acc && n < 20) begin drive(1'b1, d, byp, 1'b0, '0, acc); n++; end
    if (!acc) chk("accept_timeout", 32'(acc), 1);
  endtask

  task automatic load(input logic [AW-1:0] dl);
    logic acc;
    int   n;
    acc = 1'b0; n = 0;
    while (!acc && n < 20) begin drive(1'b0, '0, 1'b0, 1'b1, dl, acc); n++; end
    if (!acc) chk("load_timeout", 32'(acc), 1);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0, '0, acc);
  endtask

  // Monitor: pops expectations exactly in the cycle they are due.
  always @(negedge i_clk) begin
    if (!in_rst) begin
      ev = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      chk("o_valid", 32'(o_valid), 32'(ev));
      if (ev) begin
        chk("o_data", 32'(o_data), 32'(exp_q[0].data));
        chk("o_primed", 32'(o_primed), 32'(exp_q[0].primed));
        void'(exp_q.pop_front());
      end
      ew = (wr_q.size() > 0) && (wr_q[0].cyc == cyc);
      chk("o_s_wen", 32'(o_s_wen), 32'(ew));
      if (ew) begin
        chk("o_s_addr", 32'(o_s_addr), 32'(wr_q[0].addr));
        chk("o_s_data", 32'(o_s_data), 32'(wr_q[0].data));
        void'(wr_q.pop_front());
      end
      chk("o_ready", 32'(o_ready), 32'(!(cyc >= busy_lo && cyc <= busy_hi)));
      chk("s_addr_range", 32'(o_s_addr < AW'(MAXD)), 1);
    end
  end

  initial begin
    logic acc;
    int   prev, n;
    i_rst = 1'b1; i_valid = 1'b0; i_data = '0; i_bypass = 1'b0;
    i_delay_load = 1'b0; i_delay = '0;
    #1;
    chk("rst_ready", 32'(o_ready), 1);
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_wen", 32'(o_s_wen), 0);
    chk("rst_primed", 32'(o_primed), 0);
    chk("rst_data", 32'(o_data), 0);
    chk("rst_s_addr", 32'(o_s_addr), 0);
    chk("rst_s_data", 32'(o_s_data), 0);
    repeat (3) @(posedge i_clk);
    @(negedge i_clk); i_rst = 1'b0; #1 in_rst = 1'b0;

    // Delay 3, samples 1..8.
    load(AW'(3));
    for (int i = 1; i <= 8; i++) feed(DW'(i), 1'b0);
    idle(8);

    // Delay 0 clamps to 1.
    load('0);
    feed(DW'(7), 1'b0);
    feed(DW'(9), 1'b0);
    idle(8);

    // Bypass leaves the ring pointer alone.
    load(AW'(2));
    feed(DW'(16'h1111), 1'b0);
    feed(DW'(16'hABCD), 1'b1);
    idle(3);
    feed(DW'(16'h2222), 1'b0);
    feed(DW'(16'h3333), 1'b0);
    idle(8);

    // Continuous i_valid: accepts must be exactly 3+2*W cycles apart.
    load(AW'(4));
    prev = -1;
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, DW'($urandom), 1'b0, 1'b0, '0, acc);
      if (acc) begin
        if (prev >= 0) chk("accept_spacing", 32'(cyc - prev), 3 + 2 * W);
        prev = cyc;
      end
    end
    idle(8);

    // Random mix of samples, bypasses and reloads.
    for (int i = 0; i < 600; i++)
      drive(1'b1 & 1'($urandom), DW'($urandom), ($urandom % 4) == 0,
            ($urandom % 16) == 0, AW'($urandom_range(0, 12)), acc);
    idle(8);

    // Reset in the middle of a WRITE.
    load(AW'(2));
    for (int i = 0; i < 4; i++) feed(DW'($urandom), 1'b0);
    feed(DW'(16'h5A5A), 1'b0);
    n = 0;
    while (!o_s_wen && n < 20) begin idle(1); n++; end
    chk("reach_write", 32'(o_s_wen), 1);
    in_rst = 1'b1;
    i_rst = 1'b1;
    #1;
    chk("rst_mid_wen", 32'(o_s_wen), 0);
    chk("rst_mid_primed", 32'(o_primed), 0);
    chk("rst_mid_valid", 32'(o_valid), 0);
    chk("rst_mid_s_addr", 32'(o_s_addr), 0);
    exp_q.delete(); wr_q.delete(); hist.delete();
    dly_m = MAXD; k_m = 0; busy_lo = 0; busy_hi = -1;
    @(posedge i_clk);
    @(negedge i_clk); i_rst = 1'b0; #1 in_rst = 1'b0;
    @(posedge i_clk); #1;
    chk("ready_after_rst", 32'(o_ready), 1);
    load(AW'(2));
    for (int i = 0; i < 5; i++) feed(DW'($urandom), 1'b0);
    idle(8);

    // Largest delay, clamped from above; ring wraps past MAXD-1.
    load(AW'(MAXD + 5));
    n = 0;
    while (n < int'(MAXD) + 3) begin
      drive(1'b1, DW'($urandom), 1'b0, 1'b0, '0, acc);
      if (acc) n++;
    end

    n = 0;
    while ((exp_q.size() + wr_q.size()) > 0 && n < 40) begin idle(1); n++; end
    chk("drain", 32'(exp_q.size() + wr_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
